// File: rtl/intmatmul_host.sv
// Bus initiator that loads an N x N matrix and a vector into the matrix unit, then reads N results.
// Define INTMATMUL_SCAN_EN for shift-in scan loading (matrix at Addr 0, vector at Addr 1).
`ifndef GlobalAddrWidth
`define GlobalAddrWidth 16
`endif
`ifndef GlobalDataWidth
`define GlobalDataWidth 16
`endif

module intmatmul_host #(
    parameter int pVectorSize = 4,
    parameter int pWordSize   = 4,
    parameter int pWaitCycles = 2
) (
    input  logic                                         Clk,
    input  logic                                         Reset,
    input  logic                                         Start,
    input  logic [pVectorSize*pVectorSize*pWordSize-1:0] matrixIn,
    input  logic [pVectorSize*pWordSize-1:0]             vectorIn,
    output logic                                         Busy,
    output logic                                         Done,
    output logic [pVectorSize*pWordSize-1:0]             resultOut,
    output logic                                         RD,
    output logic                                         WR,
    output logic [`GlobalAddrWidth-1:0]                  Addr,
    output logic [`GlobalDataWidth-1:0]                  DataOut,
    input  logic [`GlobalDataWidth-1:0]                  DataIn
);

    localparam int N  = pVectorSize;
    localparam int NN = N * N;
    localparam int W  = pWordSize;
    localparam int AW = `GlobalAddrWidth;
    localparam int DW = `GlobalDataWidth;
    localparam int CW = $clog2(NN + pWaitCycles + 1);

`ifdef INTMATMUL_SCAN_EN
    localparam bit Scan = 1'b1;
`else
    localparam bit Scan = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_WMAT, S_WVEC, S_WAIT, S_RADDR, S_RCAP, S_DONE
    } state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [NN*W-1:0]     mat_q;
    logic [N*W-1:0]      vec_q;
    logic [N*W-1:0]      cap_q;
    logic [N*W-1:0]      res_q;
    logic                busy_q;
    logic                done_q;
    logic                rd_q;
    logic                wr_q;
    logic [AW-1:0]       addr_q;
    logic [DW-1:0]       dout_q;

    logic [CW-1:0]       nxt;
    logic [N*W-1:0]      cap_d;
    logic                unused_datain;

    assign nxt           = cnt_q + CW'(1);
    assign unused_datain = ^DataIn[DW-1:W];

    // Slot being read this cycle merged in, so the last result can be published with Done.
    always_comb begin
        cap_d = cap_q;
        cap_d[cnt_q*W +: W] = DataIn[W-1:0];
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mat_q   <= '0;
            vec_q   <= '0;
            cap_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (Start) begin
                        mat_q   <= matrixIn;
                        vec_q   <= vectorIn;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        wr_q    <= 1'b1;
                        addr_q  <= '0;
                        dout_q  <= DW'(matrixIn[W-1:0]);
                        state_q <= S_WMAT;
                    end
                end
                S_WMAT: begin
                    if (cnt_q == CW'(NN - 1)) begin
                        cnt_q   <= '0;
                        addr_q  <= Scan ? AW'(1) : AW'(NN);
                        dout_q  <= DW'(vec_q[W-1:0]);
                        state_q <= S_WVEC;
                    end else begin
                        cnt_q  <= nxt;
                        addr_q <= Scan ? AW'(0) : AW'(nxt);
                        dout_q <= DW'(mat_q[nxt*W +: W]);
                    end
                end
                S_WVEC: begin
                    if (cnt_q == CW'(N - 1)) begin
                        cnt_q   <= '0;
                        wr_q    <= 1'b0;
                        addr_q  <= '0;
                        dout_q  <= '0;
                        state_q <= S_WAIT;
                    end else begin
                        cnt_q  <= nxt;
                        addr_q <= Scan ? AW'(1) : AW'(NN) + AW'(nxt);
                        dout_q <= DW'(vec_q[nxt*W +: W]);
                    end
                end
                S_WAIT: begin
                    if (cnt_q == CW'(pWaitCycles - 1)) begin
                        cnt_q   <= '0;
                        rd_q    <= 1'b1;
                        addr_q  <= '0;
                        state_q <= S_RADDR;
                    end else begin
                        cnt_q <= nxt;
                    end
                end
                S_RADDR: begin
                    state_q <= S_RCAP;
                end
                S_RCAP: begin
                    cap_q <= cap_d;
                    if (cnt_q == CW'(N - 1)) begin
                        cnt_q   <= '0;
                        rd_q    <= 1'b0;
                        addr_q  <= '0;
                        res_q   <= cap_d;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q   <= nxt;
                        addr_q  <= AW'(nxt);
                        state_q <= S_RADDR;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign resultOut = res_q;
    assign RD        = rd_q;
    assign WR        = wr_q;
    assign Addr      = addr_q;
    assign DataOut   = dout_q;

endmodule

// File: tb/tb_intmatmul_host.sv
// Bench for intmatmul_host: a behavioural matrix-unit slave answers reads,
// results are checked against plain M*v mod 2^W arithmetic.
`timescale 1ns/1ps
`ifndef GlobalAddrWidth
`define GlobalAddrWidth 16
`endif
`ifndef GlobalDataWidth
`define GlobalDataWidth 16
`endif

module tb_intmatmul_host;

    localparam int N       = 4;
    localparam int NN      = N * N;
    localparam int W       = 4;
    localparam int WAITC   = 2;
    localparam int AW      = `GlobalAddrWidth;
    localparam int DW      = `GlobalDataWidth;
    localparam int RUN_CYC = NN + N + WAITC + 2 * N + 1;

`ifdef INTMATMUL_SCAN_EN
    localparam bit SCAN = 1'b1;
`else
    localparam bit SCAN = 1'b0;
`endif

    logic              Clk = 1'b0;
    logic              Reset;
    logic              Start;
    logic [NN*W-1:0]   matrixIn;
    logic [N*W-1:0]    vectorIn;
    logic              Busy;
    logic              Done;
    logic [N*W-1:0]    resultOut;
    logic              RD;
    logic              WR;
    logic [AW-1:0]     Addr;
    logic [DW-1:0]     DataOut;
    logic [DW-1:0]     DataIn;

    always #5 Clk = ~Clk;

    intmatmul_host #(
        .pVectorSize(N),
        .pWordSize  (W),
        .pWaitCycles(WAITC)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .matrixIn (matrixIn),
        .vectorIn (vectorIn),
        .Busy     (Busy),
        .Done     (Done),
        .resultOut(resultOut),
        .RD       (RD),
        .WR       (WR),
        .Addr     (Addr),
        .DataOut  (DataOut),
        .DataIn   (DataIn)
    );

    int checks   = 0;
    int failures = 0;

    int tm[NN];
    int tv[N];
    int smem[NN+N];
    int smi, svi;
    logic [W-1:0]    sres_v[N];
    logic [DW-W-1:0] junk = '0;

    int wr_addr[$];
    int wr_data[$];
    int rd_cyc, busy_cyc, done_cnt, done_at, proto_err, hold_err;
    bit done_busy;
    logic [N*W-1:0] hold_res, last_res, exp_res;

    assign DataIn = RD ? ((Addr < AW'(N)) ? {junk, sres_v[Addr[1:0]]} : '1) : '0;

    task automatic slave_write(int a, int d);
        int idx;
        idx = -1;
        if (SCAN) begin
            if (a == 0) begin idx = smi; smi++; end
            else if (a == 1) begin idx = NN + svi; svi++; end
        end else begin
            idx = a;
        end
        if (idx >= 0 && idx < NN + N) smem[idx] = d;
        for (int k = 0; k < N; k++) begin
            int s;
            s = 0;
            for (int j = 0; j < N; j++) s += smem[k*N+j] * smem[NN+j];
            sres_v[k] = W'(s);
        end
    endtask

    always @(negedge Clk) begin
        if (!Reset) begin
            if (RD && WR) proto_err++;
            if (!RD && !WR && (Addr !== '0 || DataOut !== '0)) proto_err++;
            if (WR) begin
                wr_addr.push_back(int'(Addr));
                wr_data.push_back(int'(DataOut));
                slave_write(int'(Addr), int'(DataOut));
            end
            if (RD) rd_cyc++;
            if (Busy) busy_cyc++;
            if (Done) begin
                done_cnt++;
                done_at   = busy_cyc;
                done_busy = Busy;
            end
            if (Busy && !Done && resultOut !== hold_res) hold_err++;
        end
    end

    function automatic logic [N*W-1:0] ref_mul();
        logic [N*W-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            int s;
            s = 0;
            for (int j = 0; j < N; j++) s += tm[k*N+j] * tv[j];
            r[k*W +: W] = W'(s % (1 << W));
        end
        return r;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < NN; i++) tm[i] = int'($urandom_range(0, 15));
        for (int j = 0; j < N; j++)  tv[j] = int'($urandom_range(0, 15));
    endtask

    task automatic load();
        for (int i = 0; i < NN; i++) matrixIn[i*W +: W] = W'(tm[i]);
        for (int j = 0; j < N; j++)  vectorIn[j*W +: W] = W'(tv[j]);
        exp_res  = ref_mul();
        hold_res = last_res;
        wr_addr.delete();
        wr_data.delete();
        rd_cyc = 0; busy_cyc = 0; done_cnt = 0; done_at = 0;
        done_busy = 1'b0; proto_err = 0; hold_err = 0;
        smi = 0; svi = 0;
        junk = (DW-W)'($urandom);
    endtask

    task automatic scramble();
        matrixIn = {$urandom, $urandom};
        vectorIn = (N*W)'($urandom);
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        scramble();
    endtask

    task automatic wait_done(string tag);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 200) begin
            @(negedge Clk); #1;
            n++;
        end
        chk({tag, " done_seen"}, done_cnt != 0, 1);
    endtask

    task automatic check_run(string tag);
        int bad;
        bad = 0;
        chk({tag, " nwr"}, wr_addr.size(), NN + N);
        for (int i = 0; i < wr_addr.size() && i < NN + N; i++) begin
            int ea, ed;
            if (i < NN) begin
                ea = SCAN ? 0 : i;
                ed = tm[i];
            end else begin
                ea = SCAN ? 1 : i;
                ed = tv[i-NN];
            end
            if (wr_addr[i] != ea || wr_data[i] != ed) bad++;
        end
        chk({tag, " wrseq"}, bad, 0);
        chk({tag, " rdcyc"}, rd_cyc, 2 * N);
        chk({tag, " ndone"}, done_cnt, 1);
        chk({tag, " done_at"}, done_at, RUN_CYC);
        chk({tag, " busy_at_done"}, done_busy, 1);
        chk({tag, " result"}, resultOut, exp_res);
        chk({tag, " proto"}, proto_err, 0);
        chk({tag, " hold"}, hold_err, 0);
        last_res = exp_res;
    endtask

    task automatic do_run(string tag);
        load();
        pulse_start();
        wait_done(tag);
        check_run(tag);
        @(negedge Clk); #1;
        chk({tag, " busy_fall"}, Busy, 0);
    endtask

    initial begin
        int hits, n;
        Reset    = 1'b1;
        Start    = 1'b0;
        matrixIn = '0;
        vectorIn = '0;
        last_res = '0;
        hold_res = '0;
        exp_res  = '0;
        #1;
        chk("rst Busy", Busy, 0);
        chk("rst Done", Done, 0);
        chk("rst RD", RD, 0);
        chk("rst WR", WR, 0);
        chk("rst Addr", Addr, 0);
        chk("rst DataOut", DataOut, 0);
        chk("rst resultOut", resultOut, 0);
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk); #1;

        for (int i = 0; i < NN; i++) tm[i] = (i / N == i % N) ? 1 : 0;
        for (int j = 0; j < N; j++)  tv[j] = j + 1;
        do_run("ident");
        chk("ident value", resultOut, 16'h4321);

        for (int i = 0; i < NN; i++) tm[i] = 2;
        for (int j = 0; j < N; j++)  tv[j] = 1;
        do_run("all2");
        chk("all2 value", resultOut, 16'h8888);

        for (int i = 0; i < NN; i++) tm[i] = 15;
        for (int j = 0; j < N; j++)  tv[j] = 15;
        do_run("ovf");
        chk("ovf value", resultOut, 16'h4444);

        for (int r = 0; r < 4; r++) begin
            randomize_inputs();
            do_run($sformatf("rand%0d", r));
        end

        randomize_inputs();
        load();
        pulse_start();
        n = 0;
        while (wr_addr.size() < NN + 1 && n < 100) begin
            @(negedge Clk); #1;
            n++;
        end
        chk("wvec reached", wr_addr.size(), NN + 1);
        Start    = 1'b1;
        matrixIn = {$urandom, $urandom};
        @(posedge Clk); #1;
        Start = 1'b0;
        wait_done("wvec");
        check_run("wvec");
        repeat (6) @(negedge Clk);
        #1;
        chk("wvec single done", done_cnt, 1);
        chk("wvec no extra wr", wr_addr.size(), NN + N);
        chk("wvec idle", Busy, 0);

        randomize_inputs();
        load();
        pulse_start();
        hits = 0;
        n = 0;
        while (hits < 2 && n < 100) begin
            @(negedge Clk); #1;
            n++;
            if (RD && Addr == AW'(2)) hits++;
        end
        chk("rcap2 reached", hits, 2);
        Reset = 1'b1;
        #1;
        chk("midrst Busy", Busy, 0);
        chk("midrst Done", Done, 0);
        chk("midrst RD", RD, 0);
        chk("midrst WR", WR, 0);
        chk("midrst Addr", Addr, 0);
        chk("midrst DataOut", DataOut, 0);
        chk("midrst resultOut", resultOut, 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        repeat (5) @(negedge Clk);
        #1;
        chk("midrst no done", done_cnt, 0);
        chk("midrst idle", Busy, 0);
        last_res = '0;
        randomize_inputs();
        do_run("post_rst");

        randomize_inputs();
        load();
        pulse_start();
        wait_done("b2b1");
        check_run("b2b1");
        randomize_inputs();
        load();
        Start = 1'b1;
        @(posedge Clk); #1;
        chk("b2b start in done ignored", Busy, 0);
        @(posedge Clk); #1;
        Start = 1'b0;
        scramble();
        chk("b2b start in idle accepted", Busy, 1);
        wait_done("b2b2");
        check_run("b2b2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/intmatmul_host.md
INTMATMUL_HOST -- requirements
Module: intmatmul_host

Interface
REQ-001 SHALL have parameter: pVectorSize, 4, vector length N (matrix is N x N).
REQ-002 SHALL have parameter: pWordSize, 4, bits per element.
REQ-003 SHALL have parameter: pWaitCycles, 2, idle cycles between last write and first read (minimum 2).
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port: Clk  in  1  clock, all state on rising edge.
REQ-006 SHALL have port: Reset  in  1  asynchronous active-high reset.
REQ-007 SHALL have port: Start  in  1  one-cycle request to run one multiply.
REQ-008 SHALL have port: matrixIn  in  N*N*pWordSize  packed matrix; element k at bits [k*pWordSize +: pWordSize].
REQ-009 SHALL have port: vectorIn  in  N*pWordSize  packed vector, same packing.
REQ-010 SHALL have port: Busy  out  1  high from the cycle after an accepted Start until Done.
REQ-011 SHALL have port: Done  out  1  one-cycle pulse when resultOut is valid.
REQ-012 SHALL have port: resultOut  out  N*pWordSize  packed result; stable until the next accepted Start.
REQ-013 SHALL have port: RD, WR  out  1 each  bus strobes to the matrix unit.
REQ-014 SHALL have port: Addr  out  `GlobalAddrWidth  bus address, zero-extended.
REQ-015 SHALL have port: DataOut  out  `GlobalDataWidth  write data, element zero-extended.
REQ-016 SHALL have port: DataIn  in  `GlobalDataWidth  read data; low pWordSize bits used.

Function
REQ-017 SHALL act as bus initiator to the matrix-multiply control unit: load matrix, load vector, wait, read N results.
REQ-018 SHALL latch matrixIn and vectorIn on the edge accepting Start; later input changes are ignored for that run.
REQ-019 SHALL accept Start only in IDLE; Start while Busy is ignored.
REQ-020 SHALL implement states IDLE -> WMAT -> WVEC -> WAIT -> RADDR -> RCAP -> DONE -> IDLE.
REQ-021 WMAT SHALL assert WR for N*N consecutive cycles, one element per cycle, elements 0..N*N-1 in order.
REQ-022 WVEC SHALL assert WR for N consecutive cycles, elements 0..N-1 in order.
REQ-023 WAIT SHALL hold RD=WR=0 for exactly pWaitCycles cycles.
REQ-024 For each result k=0..N-1: RADDR SHALL drive RD=1, Addr=k for one cycle; RCAP SHALL keep RD=1, Addr=k one more cycle and capture DataIn into result slot k at the end of that cycle.
REQ-025 After result N-1, DONE SHALL pulse Done for one cycle with Busy still high; Busy SHALL fall on the following cycle (IDLE).
REQ-026 RD and WR SHALL never be high in the same cycle; Addr and DataOut SHALL be 0 whenever both are low.
REQ-027 A full run SHALL take N*N + N + pWaitCycles + 2N + 1 cycles from the first Busy cycle to Done inclusive.
REQ-028 Start on the same cycle Done pulses SHALL be ignored; Start in the first IDLE cycle SHALL be accepted.

Reset
REQ-029 Reset SHALL asynchronously force IDLE, Busy=0, Done=0, RD=0, WR=0, Addr=0, DataOut=0, resultOut=0, counters=0.
REQ-030 Reset mid-run SHALL abandon the run; no Done is produced; a fresh Start after reset releases runs from the beginning.

Configuration
REQ-031 With INTMATMUL_SCAN_EN defined, matrix writes SHALL use Addr=0 and vector writes Addr=1 (shift-in scan loading).
REQ-032 Without INTMATMUL_SCAN_EN, matrix element k SHALL be written at Addr=k and vector element k at Addr=N*N+k (direct addressing).
REQ-033 Read addressing (Addr=k for result k) SHALL be identical in both builds.

Verification
REQ-034 Direct build, N=4, identity matrix, vector {1,2,3,4}, Start -> 16 writes Addr 0..15, 4 writes Addr 16..19, resultOut={1,2,3,4}, Done at cycle 31.
REQ-035 Scan build, all-2 matrix, vector {1,1,1,1} -> 16 writes all Addr=0, 4 writes Addr=1, every result 8 (mod 16).
REQ-036 Overflow: all-15 matrix and vector -> each result (4*225) mod 16 = 4.
REQ-037 Start pulsed during WVEC -> ignored, single Done, no extra bus cycles.
REQ-038 Reset asserted during RCAP of result 2 -> all outputs 0 immediately, no Done; subsequent Start completes correctly.
REQ-039 Back-to-back: Start in the first IDLE cycle after Done -> second run accepted with new inputs, resultOut holds first result until second Done.
